// File: rtl/valu_sequencer.sv
// valu_sequencer: command sequencer wrapped around an external combinational
// vector ALU. Each command runs one lane-wise ALU operation. A command can
// also fold the lane sum of its result into a running accumulator. A
// response is emitted for every plain command, and for the reduce command
// that closes an accumulation.
module valu_sequencer #(
    parameter int N = 18,   // lane width in bits
    parameter int V = 3     // lane count
) (
    input  logic           clk,
    input  logic           rst_n,

    // command channel
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_op,
    input  logic           cmd_reduce,
    input  logic           cmd_last,
    input  logic [V*N-1:0] cmd_a,
    input  logic [V*N-1:0] cmd_b,

    // vector ALU drive and combinational return
    output logic [V*N-1:0] alu_a,
    output logic [V*N-1:0] alu_b,
    output logic [2:0]     alu_op,
    input  logic [V*N-1:0] alu_result,
    input  logic [3:0]     alu_flags,

    // response channel
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [V*N-1:0] rsp_result,
    output logic [3:0]     rsp_flags,
    output logic           rsp_acc_ovf
);

    localparam logic [2:0] OP_LANE_SUM = 3'b101;
    localparam logic [2:0] OP_NONE     = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        REDUCE,
        RESP
    } state_t;

    state_t       state;
    logic         reduce_q;     // command being executed folds into the accumulator
    logic         last_q;       // command being executed closes the accumulation
    logic [N-1:0] acc;          // running lane-sum accumulator, mod 2^N
    logic         acc_ovf;      // sticky carry-out of the accumulator

    logic [N:0]   acc_sum;      // accumulator plus this cycle's lane sum, with carry
    logic         acc_ovf_next;

    // Unsigned add that keeps the carry-out in the top bit.
    function automatic logic [N:0] acc_add(input logic [N-1:0] x, input logic [N-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Place a scalar in lane 0 and zero every other lane.
    function automatic logic [V*N-1:0] lane0_only(input logic [N-1:0] x);
        logic [V*N-1:0] v;
        v          = '0;
        v[N-1:0]   = x;
        return v;
    endfunction

    // In REDUCE the ALU returns the lane sum in lane 0. Precompute the new accumulator value here.
    always_comb begin
        acc_sum      = acc_add(acc, alu_result[N-1:0]);
        acc_ovf_next = acc_ovf | acc_sum[N];
    end

    // Sequencer FSM. Every output is registered.
    // The ALU operand registers double as the latched copy of the command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            reduce_q    <= 1'b0;
            last_q      <= 1'b0;
            acc         <= '0;
            acc_ovf     <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= OP_NONE;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_acc_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The first cycle after reset release raises cmd_ready.
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state     <= EXEC;
                        cmd_ready <= 1'b0;
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        alu_op    <= cmd_op;
                        reduce_q  <= cmd_reduce;
                        // A last flag without reduce has no meaning and is dropped.
                        last_q    <= cmd_reduce & cmd_last;
                    end
                end

                EXEC: begin
                    if (reduce_q) begin
                        // Feed the vector result back in for a lane sum.
                        state  <= REDUCE;
                        alu_a  <= alu_result;
                        alu_b  <= '0;
                        alu_op <= OP_LANE_SUM;
                    end else begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_result  <= alu_result;
                        rsp_flags   <= alu_flags;
                        rsp_acc_ovf <= 1'b0;
                        alu_a       <= '0;
                        alu_b       <= '0;
                        alu_op      <= OP_NONE;
                    end
                end

                REDUCE: begin
                    acc     <= acc_sum[N-1:0];
                    acc_ovf <= acc_ovf_next;
                    alu_a   <= '0;
                    alu_b   <= '0;
                    alu_op  <= OP_NONE;
                    if (last_q) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_result  <= lane0_only(acc_sum[N-1:0]);
                        rsp_flags   <= alu_flags;
                        rsp_acc_ovf <= acc_ovf_next;
                    end else begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end

                RESP: begin
                    // Hold the payload until the consumer takes it.
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        // A closing reduce response starts a fresh accumulation.
                        if (reduce_q) begin
                            acc     <= '0;
                            acc_ovf <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_valu_sequencer.sv
// Directed testbench for valu_sequencer with a behavioural vector ALU stub.
module tb_valu_sequencer;

    localparam int N = 18;
    localparam int V = 3;

    logic           clk;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_op;
    logic           cmd_reduce;
    logic           cmd_last;
    logic [V*N-1:0] cmd_a;
    logic [V*N-1:0] cmd_b;
    logic [V*N-1:0] alu_a;
    logic [V*N-1:0] alu_b;
    logic [2:0]     alu_op;
    logic [V*N-1:0] alu_result;
    logic [3:0]     alu_flags;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [V*N-1:0] rsp_result;
    logic [3:0]     rsp_flags;
    logic           rsp_acc_ovf;

    int passed = 0;
    int total  = 0;

    valu_sequencer #(.N(N), .V(V)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_reduce  (cmd_reduce),
        .cmd_last    (cmd_last),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .rsp_acc_ovf (rsp_acc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: op 000 adds lane-wise, op 101 sums lanes into lane 0; flags come from lane 0.
    logic [N:0]   lane_s;
    logic [N+1:0] tot;
    logic [N-1:0] r0;
    always_comb begin
        alu_result = '0;
        alu_flags  = '0;
        lane_s     = '0;
        tot        = '0;
        r0         = '0;
        if (alu_op == 3'b000) begin
            for (int l = 0; l < V; l++) begin
                lane_s = {1'b0, alu_a[l*N +: N]} + {1'b0, alu_b[l*N +: N]};
                alu_result[l*N +: N] = lane_s[N-1:0];
                if (l == 0) begin
                    r0           = lane_s[N-1:0];
                    alu_flags[2] = lane_s[N];
                    alu_flags[3] = (alu_a[N-1] == alu_b[N-1]) && (lane_s[N-1] != alu_a[N-1]);
                end
            end
        end else if (alu_op == 3'b101) begin
            for (int l = 0; l < V; l++) begin
                tot = tot + {2'b00, alu_a[l*N +: N]};
            end
            r0                = tot[N-1:0];
            alu_result[N-1:0] = r0;
            alu_flags[2]      = |tot[N+1:N];
        end
        alu_flags[1] = (r0 == '0);
        alu_flags[0] = r0[N-1];
    end

    function automatic logic [V*N-1:0] vec(input logic [N-1:0] l2, input logic [N-1:0] l1,
                                           input logic [N-1:0] l0);
        return {l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present a command and return one cycle after the accepting edge (the EXEC cycle).
    task automatic send(input logic [2:0] op, input logic red, input logic last,
                        input logic [V*N-1:0] a, input logic [V*N-1:0] b);
        int n;
        cmd_op     = op;
        cmd_reduce = red;
        cmd_last   = last;
        cmd_a      = a;
        cmd_b      = b;
        cmd_valid  = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("accept_wait", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Non-last reduce: EXEC, REDUCE, then back to IDLE at T+3.
    task automatic reduce_mid(input string tag, input logic [V*N-1:0] a);
        send(3'b000, 1'b1, 1'b0, a, '0);
        tick();
        check({tag, "_red_op"}, {61'd0, alu_op}, 64'h5);
        check({tag, "_red_a"}, {10'd0, alu_a}, {10'd0, a});
        tick();
        check({tag, "_ready_T3"}, {63'd0, cmd_ready}, 64'd1);
        check({tag, "_no_rsp"}, {63'd0, rsp_valid}, 64'd0);
    endtask

    // Closing reduce: response at T+3, then accepted with rsp_ready=1.
    task automatic reduce_last(input string tag, input logic [V*N-1:0] a,
                               input logic [N-1:0] exp_acc, input logic exp_ovf);
        send(3'b000, 1'b1, 1'b1, a, '0);
        check({tag, "_vld_T1"}, {63'd0, rsp_valid}, 64'd0);
        tick();
        check({tag, "_vld_T2"}, {63'd0, rsp_valid}, 64'd0);
        tick();
        check({tag, "_vld_T3"}, {63'd0, rsp_valid}, 64'd1);
        check({tag, "_result"}, {10'd0, rsp_result}, {10'd0, vec(0, 0, exp_acc)});
        check({tag, "_acc_ovf"}, {63'd0, rsp_acc_ovf}, {63'd0, exp_ovf});
        check({tag, "_flags"}, {60'd0, rsp_flags}, 64'd0);
        tick();
        check({tag, "_drained"}, {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'b000;
        cmd_reduce = 1'b0;
        cmd_last   = 1'b0;
        cmd_a      = '0;
        cmd_b      = '0;
        rsp_ready  = 1'b1;

        // Reset state
        tick();
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_result", {10'd0, rsp_result}, 64'd0);
        check("rst_rsp_flags", {60'd0, rsp_flags}, 64'd0);
        check("rst_acc_ovf", {63'd0, rsp_acc_ovf}, 64'd0);
        check("rst_alu_a", {10'd0, alu_a}, 64'd0);
        check("rst_alu_op", {61'd0, alu_op}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Plain command: {1,2,3} + {10,20,30}
        send(3'b000, 1'b0, 1'b0, vec(3, 2, 1), vec(30, 20, 10));
        check("exec_alu_a", {10'd0, alu_a}, {10'd0, vec(3, 2, 1)});
        check("exec_alu_b", {10'd0, alu_b}, {10'd0, vec(30, 20, 10)});
        check("exec_alu_op", {61'd0, alu_op}, 64'd0);
        check("exec_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("exec_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        tick();
        check("plain_vld_T2", {63'd0, rsp_valid}, 64'd1);
        check("plain_result", {10'd0, rsp_result}, {10'd0, vec(33, 22, 11)});
        check("plain_flags", {60'd0, rsp_flags}, 64'd0);
        check("plain_acc_ovf", {63'd0, rsp_acc_ovf}, 64'd0);
        check("resp_alu_op", {61'd0, alu_op}, 64'd0);
        tick();
        check("plain_drained", {63'd0, rsp_valid}, 64'd0);
        check("plain_idle_ready", {63'd0, cmd_ready}, 64'd1);

        // Reduce chain of three {1,1,1} commands
        reduce_mid("chain1", vec(1, 1, 1));
        reduce_mid("chain2", vec(1, 1, 1));
        reduce_last("chain3", vec(1, 1, 1), 18'd9, 1'b0);

        // last without reduce is ignored; lane-0 carry and zero flags
        send(3'b000, 1'b0, 1'b1, vec(0, 0, 18'h3FFFF), vec(0, 0, 1));
        tick();
        check("carry_vld", {63'd0, rsp_valid}, 64'd1);
        check("carry_result", {10'd0, rsp_result}, 64'd0);
        check("carry_flags", {60'd0, rsp_flags}, 64'h6);
        check("carry_acc_ovf", {63'd0, rsp_acc_ovf}, 64'd0);
        tick();

        // Backpressure: signed overflow and negative flags
        rsp_ready = 1'b0;
        send(3'b000, 1'b0, 1'b0, vec(0, 0, 18'h1FFFF), vec(0, 0, 1));
        tick();
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_result", {10'd0, rsp_result}, {10'd0, vec(0, 0, 18'h20000)});
            check("bp_flags", {60'd0, rsp_flags}, 64'h9);
            check("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        check("bp_valid6", {63'd0, rsp_valid}, 64'd1);
        tick();
        check("bp_drained", {63'd0, rsp_valid}, 64'd0);
        check("bp_idle_ready", {63'd0, cmd_ready}, 64'd1);

        // Accumulator wrap sets the sticky overflow, which clears after the response
        reduce_mid("wrap_fill", vec(0, 0, 18'h3FFFF));
        reduce_last("wrap", vec(0, 1, 1), 18'h00001, 1'b1);
        reduce_last("post_wrap", vec(0, 2, 1), 18'd3, 1'b0);

        // Reset during REDUCE of a non-last reduce discards the partial sum
        send(3'b000, 1'b1, 1'b0, vec(7, 7, 7), '0);
        tick();
        check("mid_red_op", {61'd0, alu_op}, 64'h5);
        rst_n = 1'b0;
        #1;
        check("async_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("async_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("async_alu_op", {61'd0, alu_op}, 64'd0);
        check("async_alu_a", {10'd0, alu_a}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rerel_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rerel_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        reduce_last("after_rst", vec(1, 2, 2), 18'd5, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/valu_sequencer.md
VALU_SEQUENCER -- requirements
Module: valu_sequencer

Interface
REQ-001 SHALL have parameter N, default 18, lane width in bits.
REQ-002 SHALL have parameter V, default 3, lane count; lane-sum opcode is fixed at 3'b101.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake.
REQ-006 SHALL have port cmd_op  input  3  lane operation for the vector ALU.
REQ-007 SHALL have port cmd_reduce  input  1  1 = lane-sum the op result and add it to the accumulator.
REQ-008 SHALL have port cmd_last  input  1  with cmd_reduce, closes the accumulation and emits a response.
REQ-009 SHALL have ports cmd_a, cmd_b  input  V*N each  packed operand vectors, lane 0 in LSBs.
REQ-010 SHALL have ports alu_a, alu_b output V*N, alu_op output 3: drive the vector ALU.
REQ-011 SHALL have ports alu_result input V*N, alu_flags input 4 {overflow, carry, zero, negative}: combinational ALU return.
REQ-012 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-013 SHALL have ports rsp_result output V*N, rsp_flags output 4, rsp_acc_ovf output 1: response payload.

Function
REQ-014 SHALL implement states IDLE, EXEC, REDUCE, RESP.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid & cmd_ready; all cmd fields latched at acceptance.
REQ-016 IDLE -> EXEC on acceptance; otherwise remain in IDLE.
REQ-017 In EXEC, alu_a/alu_b/alu_op SHALL come from latched registers; alu_result and alu_flags captured at end of EXEC.
REQ-018 EXEC -> RESP if latched reduce=0; EXEC -> REDUCE if reduce=1.
REQ-019 In REDUCE, alu_a = captured result, alu_b = 0, alu_op = 3'b101; lane 0 of alu_result added to the accumulator, mod 2^N.
REQ-020 Accumulator carry-out beyond N bits SHALL set sticky acc_ovf; cleared only when the closing response is accepted or on reset.
REQ-021 REDUCE -> RESP if latched last=1, else REDUCE -> IDLE.
REQ-022 RESP: rsp_valid=1; payload stable until rsp_valid & rsp_ready; then -> IDLE.
REQ-023 Non-reduce payload: rsp_result = captured EXEC result; rsp_flags = EXEC flags; rsp_acc_ovf = 0.
REQ-024 Reduce payload: rsp_result lane 0 = accumulator incl. final add, lanes 1..V-1 = 0; rsp_flags = REDUCE flags; rsp_acc_ovf = sticky flag.
REQ-025 Accumulator and acc_ovf SHALL clear on acceptance of a reduce response; unchanged by non-reduce commands.
REQ-026 Latency: accept at cycle T -> rsp_valid at T+2 (non-reduce) or T+3 (reduce+last); non-last reduce -> cmd_ready again at T+3.
REQ-027 Outside EXEC/REDUCE, alu_a, alu_b = 0 and alu_op = 3'b000.
REQ-028 rsp_valid SHALL never be 1 outside RESP; no new command accepted while rsp_valid=1.
REQ-029 cmd_last with cmd_reduce=0 SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, cmd_ready=0 while asserted then 1 on first cycle after release, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_acc_ovf=0, accumulator=0, alu outputs 0/3'b000.
REQ-031 Reset mid-operation (EXEC, REDUCE, RESP) SHALL discard the command and partial accumulation; no response emitted.

Verification (bench ALU stub: op 000 = lane-wise A+B, op 101 = lane sum into lane 0, flags per lane-0 result)
REQ-032 Non-reduce: op 000, A={1,2,3}, B={10,20,30}, rsp_ready=1 -> rsp_valid at T+2, rsp_result={11,22,33}, acc_ovf=0.
REQ-033 Reduce chain: three reduce cmds op 000, A={1,1,1}, B={0,0,0}, last on third -> one response, lane 0 = 9, lanes 1,2 = 0.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and payload held, cmd_ready=0 throughout; accepted on 6th cycle, IDLE next.
REQ-035 Wrap: accumulator 0x3FFFF then reduce adding lane sum 2 with last -> lane 0 = 0x00001, rsp_acc_ovf=1; next reduce response acc_ovf=0.
REQ-036 Reset in REDUCE of a non-last reduce, then a reduce+last command of lane sum 5 -> lane 0 = 5 (prior accumulation lost).
